frog_collision: RTL and testbench

Consumer of the car position bus driven by the car movement block: once per video frame it samples the frog box and the four car x positions, scans the cars one per cycle for overlap, and runs the hit / death / respawn / lives sequence. It sits between car movement and frog control on one side and the renderer and score logic on the other. Its outputs command frog respawn and report lives and game-over.

---
 rtl/frog_collision_if.sv | 29 ++
 rtl/frog_collision.sv | 164 ++++++++++++++++
 tb/tb_frog_collision.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/frog_collision_if.sv
// Frog/car position bus between car movement + frog control (master) and frog_collision (slave).
// Carries the per-frame position snapshot inputs and the collision/lives status outputs.
interface frog_collision_if;
  // frame_tick is a one-cycle strobe with no back-pressure; positions must be
  // stable in the cycle frame_tick is high, which is the only cycle they are sampled.
  logic       frame_tick;
  logic [9:0] frog_x;
  logic [9:0] frog_y;
  logic [9:0] car_x1;
  logic [9:0] car_x2;
  logic [9:0] car_x3;
  logic [9:0] car_x4;
  logic       hit;
  logic [1:0] hit_lane;
  logic       dead;
  logic       frog_reset;
  logic [1:0] lives;
  logic       game_over;

  modport master (
    output frame_tick, frog_x, frog_y, car_x1, car_x2, car_x3, car_x4,
    input  hit, hit_lane, dead, frog_reset, lives, game_over
  );

  modport slave (
    input  frame_tick, frog_x, frog_y, car_x1, car_x2, car_x3, car_x4,
    output hit, hit_lane, dead, frog_reset, lives, game_over
  );
endinterface

// File: rtl/frog_collision.sv
// Per-frame frog vs car overlap scan (one lane per cycle) with hit/death/respawn/lives sequencing.
// Define COLLISION_INVULN_EN to add a post-respawn grace period of INVULN_FRAMES frames.
module frog_collision #(
  parameter int FROG_W        = 32,
  parameter int FROG_H        = 32,
  parameter int CAR_W         = 64,
  parameter int CAR_H         = 32,
  parameter int LANE_Y1       = 96,
  parameter int LANE_Y2       = 160,
  parameter int LANE_Y3       = 224,
  parameter int LANE_Y4       = 288,
  parameter int H_VISIBLE     = 640,
  parameter int LIVES         = 3,
`ifdef COLLISION_INVULN_EN
  parameter int INVULN_FRAMES = 120,
`endif
  parameter int DEATH_FRAMES  = 60
) (
  input  logic              CLK,
  input  logic              RST,
  frog_collision_if.slave   bus,
  output logic [2:0]        state_dbg
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SCAN   = 3'd1,
    S_HIT    = 3'd2,
    S_DEATH  = 3'd3,
`ifdef COLLISION_INVULN_EN
    S_INVULN = 3'd4,
`endif
    S_OVER   = 3'd5
  } state_t;

  localparam logic [10:0] FW   = 11'(FROG_W);
  localparam logic [10:0] FH   = 11'(FROG_H);
  localparam logic [10:0] CW   = 11'(CAR_W);
  localparam logic [10:0] CH   = 11'(CAR_H);
  localparam logic [10:0] LY1  = 11'(LANE_Y1);
  localparam logic [10:0] LY2  = 11'(LANE_Y2);
  localparam logic [10:0] LY3  = 11'(LANE_Y3);
  localparam logic [10:0] LY4  = 11'(LANE_Y4);
  localparam logic [10:0] HV   = 11'(H_VISIBLE);
  localparam logic [1:0]  L0   = 2'(LIVES);
  localparam logic [7:0]  DF   = 8'(DEATH_FRAMES);

  state_t     state_q, state_n;
  logic [9:0] snap_fx, snap_fy;
  logic [9:0] snap_car [4];
  logic [1:0] k_q;
  logic [7:0] cnt_q;
  logic [1:0] lives_q;
  logic [1:0] hit_lane_q;
  logic       hit_c, frog_reset_c;

  logic [10:0] lane_y, cx_e, fx_e, fy_e;
  logic        overlap;

  // All sums are 11 bits wide so frog/car right and bottom edges never wrap.
  always_comb begin
    case (k_q)
      2'd0:    lane_y = LY1;
      2'd1:    lane_y = LY2;
      2'd2:    lane_y = LY3;
      default: lane_y = LY4;
    endcase
    cx_e    = {1'b0, snap_car[k_q]};
    fx_e    = {1'b0, snap_fx};
    fy_e    = {1'b0, snap_fy};
    overlap = (cx_e < HV) &&
              (fx_e + FW > cx_e) && (cx_e + CW > fx_e) &&
              (fy_e + FH > lane_y) && (lane_y + CH > fy_e);
  end

  always_comb begin
    state_n      = state_q;
    hit_c        = 1'b0;
    frog_reset_c = 1'b0;
    case (state_q)
      S_IDLE:  if (bus.frame_tick) state_n = S_SCAN;
      S_SCAN: begin
        if (overlap)           state_n = S_HIT;
        else if (k_q == 2'd3)  state_n = S_IDLE;
      end
      S_HIT: begin
        hit_c   = 1'b1;
        state_n = (lives_q == 2'd1) ? S_OVER : S_DEATH;
      end
      S_DEATH: begin
        if (cnt_q == 8'd0) begin
          frog_reset_c = 1'b1;
`ifdef COLLISION_INVULN_EN
          state_n      = S_INVULN;
`else
          state_n      = S_IDLE;
`endif
        end
      end
`ifdef COLLISION_INVULN_EN
      S_INVULN: if (cnt_q == 8'd0) state_n = S_IDLE;
`endif
      S_OVER:  state_n = S_OVER;
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= S_IDLE;
      snap_fx    <= '0;
      snap_fy    <= '0;
      for (int i = 0; i < 4; i++) snap_car[i] <= '0;
      k_q        <= '0;
      cnt_q      <= '0;
      lives_q    <= L0;
      hit_lane_q <= '0;
    end else begin
      state_q <= state_n;
      case (state_q)
        S_IDLE: begin
          if (bus.frame_tick) begin
            snap_fx     <= bus.frog_x;
            snap_fy     <= bus.frog_y;
            snap_car[0] <= bus.car_x1;
            snap_car[1] <= bus.car_x2;
            snap_car[2] <= bus.car_x3;
            snap_car[3] <= bus.car_x4;
            k_q         <= 2'd0;
          end
        end
        S_SCAN: begin
          if (overlap) hit_lane_q <= k_q;
          else         k_q        <= k_q + 2'd1;
        end
        S_HIT: begin
          lives_q <= lives_q - 2'd1;
          cnt_q   <= DF;
        end
        S_DEATH: begin
`ifdef COLLISION_INVULN_EN
          if (cnt_q == 8'd0)        cnt_q <= 8'(INVULN_FRAMES);
          else if (bus.frame_tick)  cnt_q <= cnt_q - 8'd1;
`else
          if (cnt_q != 8'd0 && bus.frame_tick) cnt_q <= cnt_q - 8'd1;
`endif
        end
`ifdef COLLISION_INVULN_EN
        S_INVULN: if (cnt_q != 8'd0 && bus.frame_tick) cnt_q <= cnt_q - 8'd1;
`endif
        default: ;
      endcase
    end
  end

  assign bus.hit        = hit_c;
  assign bus.frog_reset = frog_reset_c;
  assign bus.hit_lane   = hit_lane_q;
  assign bus.lives      = lives_q;
  assign bus.dead       = (state_q == S_DEATH) || (state_q == S_OVER);
  assign bus.game_over  = (state_q == S_OVER);
  assign state_dbg      = state_q;

endmodule

// File: tb/tb_frog_collision.sv
// Bench for frog_collision: directed test-plan steps followed by random frames,
// checked against a frame-level game model (lives, death/grace frame budgets, first overlapping lane).
module tb_frog_collision;
  localparam int LANE0_Y    = 96;
  localparam int LANE_PITCH = 64;
  localparam int DEATH_N    = 60;
  localparam int INVULN_N   = 120;
  localparam int START_LIVES = 3;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic [2:0] state_dbg;
  int tests = 0;
  int fails = 0;

  int m_lives = START_LIVES;
  int m_death = 0;
  int m_invuln = 0;
  int m_over = 0;
  int m_last = 0;

  frog_collision_if bus ();
  frog_collision dut (.CLK(CLK), .RST(RST), .bus(bus), .state_dbg(state_dbg));

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Lowest lane whose car box strictly overlaps the frog box, or -1.
  function automatic int first_hit(input int fx, input int fy,
                                   input int c1, input int c2, input int c3, input int c4);
    int c[4];
    int ly;
    c = '{c1, c2, c3, c4};
    for (int l = 0; l < 4; l++) begin
      ly = LANE0_Y + l * LANE_PITCH;
      if (c[l] < 640 && fx + 32 > c[l] && c[l] + 64 > fx && fy + 32 > ly && ly + 32 > fy)
        return l;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_lives = START_LIVES; m_death = 0; m_invuln = 0; m_over = 0; m_last = 0;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_hit"}, bus.hit, 0);
    check({tag, "_hit_lane"}, bus.hit_lane, 0);
    check({tag, "_dead"}, bus.dead, 0);
    check({tag, "_frog_reset"}, bus.frog_reset, 0);
    check({tag, "_lives"}, bus.lives, START_LIVES);
    check({tag, "_game_over"}, bus.game_over, 0);
    check({tag, "_state_idle"}, state_dbg, 0);
  endtask

  // One RST edge, then a few quiet cycles in which no pulse may appear.
  task automatic apply_reset(input string tag);
    int pulses;
    @(negedge CLK); RST = 1'b1; bus.frame_tick = 1'b0;
    @(negedge CLK); RST = 1'b0;
    model_reset();
    check_reset_values(tag);
    pulses = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge CLK);
      if (bus.hit === 1'b1 || bus.frog_reset === 1'b1) pulses++;
    end
    check({tag, "_no_pulse"}, pulses, 0);
  endtask

  task automatic do_frame(input string tag, input int fx, input int fy,
                          input int c1, input int c2, input int c3, input int c4);
    int exp_lane, exp_rst;
    int hit_n, hit_off, rst_n, rst_off;
    exp_lane = -1;
    exp_rst  = 0;
    if (m_over != 0) begin
    end else if (m_death > 0) begin
      m_death--;
      if (m_death == 0) begin
        exp_rst = 1;
`ifdef COLLISION_INVULN_EN
        m_invuln = INVULN_N;
`endif
      end
    end else if (m_invuln > 0) begin
      m_invuln--;
    end else begin
      exp_lane = first_hit(fx, fy, c1, c2, c3, c4);
      if (exp_lane >= 0) begin
        m_lives--;
        m_last = exp_lane;
        if (m_lives == 0) m_over = 1;
        else              m_death = DEATH_N;
      end
    end

    @(negedge CLK);
    bus.frog_x = 10'(fx); bus.frog_y = 10'(fy);
    bus.car_x1 = 10'(c1); bus.car_x2 = 10'(c2); bus.car_x3 = 10'(c3); bus.car_x4 = 10'(c4);
    bus.frame_tick = 1'b1;
    @(negedge CLK);
    bus.frame_tick = 1'b0;
    hit_n = 0; hit_off = -1; rst_n = 0; rst_off = -1;
    for (int o = 1; o <= 7; o++) begin
      if (bus.hit === 1'b1)        begin hit_n++; hit_off = o; end
      if (bus.frog_reset === 1'b1) begin rst_n++; rst_off = o; end
      if (o < 7) @(negedge CLK);
    end

    check({tag, "_hit_count"}, hit_n, (exp_lane >= 0) ? 1 : 0);
    if (exp_lane >= 0) check({tag, "_hit_cycle"}, hit_off, 2 + exp_lane);
    check({tag, "_hit_lane"}, bus.hit_lane, m_last);
    check({tag, "_frog_reset_count"}, rst_n, exp_rst);
    if (exp_rst != 0) check({tag, "_frog_reset_cycle"}, rst_off, 1);
    check({tag, "_lives"}, bus.lives, m_lives);
    check({tag, "_dead"}, bus.dead, (m_over != 0 || m_death > 0) ? 1 : 0);
    check({tag, "_game_over"}, bus.game_over, m_over);
    if (m_over == 0 && m_death == 0 && m_invuln == 0) check({tag, "_state_idle"}, state_dbg, 0);
  endtask

  // Keep the frog sitting on a lane-1 car while the death/grace budget runs out.
  task automatic run_out_death(input string tag);
    int guard;
    guard = 0;
    while ((m_death > 0 || m_invuln > 0) && guard < 400) begin
      do_frame(tag, 100, 96, 100, 100, 100, 100);
      guard++;
    end
    check({tag, "_budget"}, (m_death == 0 && m_invuln == 0) ? 1 : 0, 1);
  endtask

  initial begin
    int fx, fy, c[4], hits, rst_pulses;
    bus.frame_tick = 1'b0;
    bus.frog_x = '0; bus.frog_y = '0;
    bus.car_x1 = '0; bus.car_x2 = '0; bus.car_x3 = '0; bus.car_x4 = '0;
    repeat (3) @(negedge CLK);
    RST = 1'b0;
    check_reset_values("reset");

    do_frame("no_overlap", 300, 400, 0, 100, 200, 300);
    do_frame("touching_edge", 144, 96, 80, 700, 700, 700);
    do_frame("off_screen", 690, 96, 700, 700, 700, 700);
    do_frame("lane2_hit", 100, 170, 0, 80, 0, 0);
    run_out_death("lane2_death");
`ifdef COLLISION_INVULN_EN
    do_frame("after_grace_hit", 100, 96, 100, 0, 0, 0);
    run_out_death("grace2_death");
`endif
    do_frame("priority_hit", 200, 96, 190, 700, 190, 700);
    run_out_death("priority_death");
    do_frame("third_hit", 300, 224, 0, 0, 290, 0);
    for (int i = 0; i < 4; i++) do_frame("over_overlap", 300, 224, 0, 0, 290, 0);
    apply_reset("reset_after_over");

    do_frame("pre_rst_hit", 400, 288, 700, 700, 700, 390);
    for (int i = 0; i < 5; i++) do_frame("pre_rst_death", 400, 288, 700, 700, 700, 390);
    apply_reset("rst_in_death");

    // RST sampled at the edge ending cycle T+2 of a scan that would hit lane 4.
    @(negedge CLK);
    bus.frog_x = 10'd400; bus.frog_y = 10'd288;
    bus.car_x1 = 10'd700; bus.car_x2 = 10'd700; bus.car_x3 = 10'd700; bus.car_x4 = 10'd400;
    bus.frame_tick = 1'b1;
    @(negedge CLK); bus.frame_tick = 1'b0;
    @(negedge CLK); RST = 1'b1;
    @(negedge CLK); RST = 1'b0;
    check_reset_values("rst_mid_scan");
    hits = 0; rst_pulses = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge CLK);
      if (bus.hit === 1'b1) hits++;
      if (bus.frog_reset === 1'b1) rst_pulses++;
    end
    check("rst_mid_scan_hits", hits, 0);
    check("rst_mid_scan_frog_reset", rst_pulses, 0);
    check("rst_mid_scan_lives", bus.lives, START_LIVES);
    model_reset();

    for (int n = 0; n < 150; n++) begin
      if (m_over != 0) apply_reset("rand_reset");
      fx = $urandom_range(0, 700);
      fy = $urandom_range(60, 330);
      for (int l = 0; l < 4; l++) begin
        if ($urandom_range(0, 1) == 1) begin
          c[l] = fx + $urandom_range(0, 128) - 64;
          if (c[l] < 0) c[l] = 0;
        end else begin
          c[l] = $urandom_range(0, 1023);
        end
      end
      do_frame("random", fx, fy, c[0], c[1], c[2], c[3]);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #3000000;
    fails++;
    $display("FAIL timeout observed=running expected=finished");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $fatal(1, "timeout");
  end
endmodule
